// File: rtl/decoder_2to4.sv
// decoder_2to4
//   Registered binary-to-one-hot line decoder. The select code `a` is sampled
//   on an enabled rising edge and exactly one line of `d` is driven active.
//   The output is registered, so downstream logic sees a glitch-free word.
//
// Parameters
//   IN_W        select width; output width is 2**IN_W
//   ACTIVE_LOW  0: selected line is 1, others 0
//               1: selected line is 0, others 1
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active high
//   en       decode enable; `a` is sampled only when high
//   a        binary select code
//   d        registered decoded lines
//   d_valid  high for the cycle in which `d` holds a freshly decoded value
module decoder_2to4 #(
  parameter int IN_W       = 2,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IN_W-1:0]      a,
  output logic [2**IN_W-1:0]   d,
  output logic                 d_valid
);

  localparam int OUT_W = 2**IN_W;

  // Inactive word; XOR-ing the active-high one-hot with it yields the
  // active-low form when ACTIVE_LOW is set.
  localparam logic [OUT_W-1:0] IDLE_WORD = {OUT_W{ACTIVE_LOW}};

  logic [OUT_W-1:0] one_hot;
  logic [OUT_W-1:0] decoded;

  always_comb begin
    one_hot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (a == IN_W'(i)) begin
        one_hot[i] = 1'b1;
      end
    end
  end

  assign decoded = one_hot ^ IDLE_WORD;

  always_ff @(posedge clk) begin
    if (rst) begin
      d       <= IDLE_WORD;
      d_valid <= 1'b0;
    end else if (en) begin
      d       <= decoded;
      d_valid <= 1'b1;
    end else begin
      // d holds its last decoded word; only the valid flag drops.
      d_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_2to4.sv
// tb_decoder_2to4
//   Drives an active-high and an active-low decoder from the same inputs and
//   checks both against directed tables and a behavioural reference model.
module tb_decoder_2to4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] a   = 2'b00;
  logic [3:0] d_hi, d_lo;
  logic       v_hi, v_lo;

  int vectors = 0;
  int errors  = 0;

  // Reference model (active-high view); active-low expectation is its inverse.
  logic [3:0] exp_d = 4'b0000;
  logic       exp_v = 1'b0;
  logic [1:0] last_a = 2'b00;

  always #5 clk = ~clk;

  decoder_2to4 #(.IN_W(2), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .a(a), .d(d_hi), .d_valid(v_hi)
  );

  decoder_2to4 #(.IN_W(2), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .a(a), .d(d_lo), .d_valid(v_lo)
  );

  // Apply one set of inputs for one edge, advance the model, sample after it.
  task automatic drive(input logic r, input logic e, input logic [1:0] av);
    @(negedge clk);
    rst = r;
    en  = e;
    a   = av;
    @(posedge clk);
    if (r) begin
      exp_d = 4'b0000;
      exp_v = 1'b0;
    end else if (e) begin
      exp_d  = 4'(2 ** int'(av));
      exp_v  = 1'b1;
      last_a = av;
    end else begin
      exp_v = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 2'b11);
      vectors++;
      if (d_hi !== 4'b0000 || v_hi !== 1'b0) begin
        errors++;
        $display("FAIL reset_hi[%0d]: d=%b valid=%b, need d=0000 valid=0", k, d_hi, v_hi);
      end
      vectors++;
      if (d_lo !== 4'b1111 || v_lo !== 1'b0) begin
        errors++;
        $display("FAIL reset_lo[%0d]: d=%b valid=%b, need d=1111 valid=0", k, d_lo, v_lo);
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] tbl_hi [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] tbl_lo [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'(i));
      vectors++;
      if (d_hi !== tbl_hi[i] || v_hi !== 1'b1) begin
        errors++;
        $display("FAIL sweep_hi a=%0d: d=%b valid=%b, need d=%b valid=1", i, d_hi, v_hi, tbl_hi[i]);
      end
      vectors++;
      if (d_lo !== tbl_lo[i] || v_lo !== 1'b1) begin
        errors++;
        $display("FAIL sweep_lo a=%0d: d=%b valid=%b, need d=%b valid=1", i, d_lo, v_lo, tbl_lo[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 2'b10);
    vectors++;
    if (d_hi !== 4'b0100 || v_hi !== 1'b1) begin
      errors++;
      $display("FAIL hold_load: d=%b valid=%b, need d=0100 valid=1", d_hi, v_hi);
    end
    drive(1'b0, 1'b0, 2'b01);
    vectors++;
    if (d_hi !== 4'b0100 || v_hi !== 1'b0) begin
      errors++;
      $display("FAIL hold_keep_hi: d=%b valid=%b, need d=0100 valid=0", d_hi, v_hi);
    end
    vectors++;
    if (d_lo !== 4'b1011 || v_lo !== 1'b0) begin
      errors++;
      $display("FAIL hold_keep_lo: d=%b valid=%b, need d=1011 valid=0", d_lo, v_lo);
    end
    drive(1'b0, 1'b1, 2'b01);
    vectors++;
    if (d_hi !== 4'b0010 || v_hi !== 1'b1) begin
      errors++;
      $display("FAIL hold_resume: d=%b valid=%b, need d=0010 valid=1", d_hi, v_hi);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b1, 2'b01);
    vectors++;
    if (d_hi !== 4'b0010 || v_hi !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: d=%b valid=%b, need d=0010 valid=1", d_hi, v_hi);
    end
    drive(1'b1, 1'b1, 2'b11);
    vectors++;
    if (d_hi !== 4'b0000 || v_hi !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hit_hi: d=%b valid=%b, need d=0000 valid=0", d_hi, v_hi);
    end
    vectors++;
    if (d_lo !== 4'b1111 || v_lo !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hit_lo: d=%b valid=%b, need d=1111 valid=0", d_lo, v_lo);
    end
    drive(1'b0, 1'b1, 2'b11);
    vectors++;
    if (d_hi !== 4'b1000 || v_hi !== 1'b1) begin
      errors++;
      $display("FAIL midrst_release: d=%b valid=%b, need d=1000 valid=1", d_hi, v_hi);
    end
  endtask

  task automatic test_random();
    int idx;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
      vectors++;
      if (d_hi !== exp_d || v_hi !== exp_v) begin
        errors++;
        $display("FAIL rand_hi[%0d]: d=%b valid=%b, need d=%b valid=%b", n, d_hi, v_hi, exp_d, exp_v);
      end
      vectors++;
      if (d_lo !== ~exp_d || v_lo !== exp_v) begin
        errors++;
        $display("FAIL rand_lo[%0d]: d=%b valid=%b, need d=%b valid=%b", n, d_lo, v_lo, ~exp_d, exp_v);
      end
      if (v_hi === 1'b1) begin
        idx = -1;
        for (int i = 0; i < 4; i++) if (d_hi[i] === 1'b1) idx = i;
        vectors++;
        if ($countones(d_hi) != 1 || idx != int'(last_a)) begin
          errors++;
          $display("FAIL rand_onehot[%0d]: d=%b active_idx=%0d, need one line at idx=%0d", n, d_hi, idx, last_a);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_hold();
    test_mid_reset();
    test_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
